// File: rtl/and_operand_sequencer_if.sv
// Operand-in / result-out handshake bundle for and_operand_sequencer.
// master = upstream/downstream environment, slave = the sequencer.
interface and_operand_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ready;

  modport master (
    output in_data, in_valid, result_ready,
    input  in_ready, result, result_valid
  );

  modport slave (
    input  in_data, in_valid, result_ready,
    output in_ready, result, result_valid
  );
endinterface

// File: rtl/and_operand_sequencer.sv
// Two-beat operand loader around an external 4-bit AND unit with a held result.
// Optional ALU_ZERO_FLAG_EN adds a registered zero_flag alongside the result.
module and_operand_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  and_operand_sequencer_if.slave bus,
  output logic [WIDTH-1:0]     inputA,
  output logic [WIDTH-1:0]     inputB,
  input  logic [WIDTH-1:0]     outputC,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic                 zero_flag
`endif
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] reg_a_reg;
  logic [WIDTH-1:0] reg_b_reg;
  logic [WIDTH-1:0] result_reg;
  logic             result_valid_reg;
  logic [CNT_W-1:0] op_count_reg;
`ifdef ALU_ZERO_FLAG_EN
  logic             zero_flag_reg;
`endif

  // Reset must block acceptance in the very cycle it is asserted.
  assign bus.in_ready     = ((state_reg == LOAD_A) || (state_reg == LOAD_B)) && !reset;
  assign bus.result       = result_reg;
  assign bus.result_valid = result_valid_reg;
  assign inputA           = reg_a_reg;
  assign inputB           = reg_b_reg;
  assign busy             = (state_reg != LOAD_A);
  assign op_count         = op_count_reg;
`ifdef ALU_ZERO_FLAG_EN
  assign zero_flag        = zero_flag_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= LOAD_A;
      reg_a_reg        <= '0;
      reg_b_reg        <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      op_count_reg     <= '0;
`ifdef ALU_ZERO_FLAG_EN
      zero_flag_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        LOAD_A: begin
          if (bus.in_valid) begin
            reg_a_reg <= bus.in_data;
            state_reg <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            reg_b_reg <= bus.in_data;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          // One cycle for the AND unit to settle on the registered operands.
          result_reg       <= outputC;
          result_valid_reg <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
          zero_flag_reg    <= (outputC == '0);
`endif
          state_reg        <= HOLD;
        end
        HOLD: begin
          if (bus.result_ready) begin
            result_valid_reg <= 1'b0;
            op_count_reg     <= op_count_reg + CNT_W'(1);
`ifdef ALU_ZERO_FLAG_EN
            zero_flag_reg    <= 1'b0;
`endif
            state_reg        <= LOAD_A;
          end
        end
        default: state_reg <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_and_operand_sequencer.sv
// Randomized and directed bench for and_operand_sequencer against an operand-count model.
// Build with ALU_ZERO_FLAG_EN defined to also cover zero_flag.
module tb_and_operand_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] inputA, inputB, outputC;
  logic             busy;
  logic [CNT_W-1:0] op_count;
`ifdef ALU_ZERO_FLAG_EN
  logic             zero_flag;
`endif

  and_operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

  and_operand_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .inputA   (inputA),
    .inputB   (inputB),
    .outputC  (outputC),
    .busy     (busy),
    .op_count (op_count)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .zero_flag(zero_flag)
`endif
  );

  // The external AND unit.
  assign outputC = inputA & inputB;

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: how many operands of the current operation have been taken,
  // and whether the computed result is still waiting to be consumed.
  int               m_ops = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;
  bit               m_rv = 1'b0, m_zf = 1'b0;
  int               m_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_ops <= 0; m_a <= '0; m_b <= '0; m_res <= '0;
      m_rv <= 1'b0; m_zf <= 1'b0; m_cnt <= 0;
    end else if (m_ops < 2) begin
      if (bus.in_valid) begin
        if (m_ops == 0) m_a <= bus.in_data;
        else            m_b <= bus.in_data;
        m_ops <= m_ops + 1;
      end
    end else if (!m_rv) begin
      m_res <= m_a & m_b;
      m_zf  <= ((m_a & m_b) == '0);
      m_rv  <= 1'b1;
    end else if (bus.result_ready) begin
      m_rv  <= 1'b0;
      m_zf  <= 1'b0;
      m_ops <= 0;
      m_cnt <= (m_cnt + 1) % (1 << CNT_W);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!reset && m_ops < 2));
      chk("busy", 32'(busy), 32'(m_ops != 0));
      chk("result_valid", 32'(bus.result_valid), 32'(m_rv));
      chk("result", 32'(bus.result), 32'(m_res));
      chk("inputA", 32'(inputA), 32'(m_a));
      chk("inputB", 32'(inputB), 32'(m_b));
      chk("op_count", 32'(op_count), 32'(m_cnt));
`ifdef ALU_ZERO_FLAG_EN
      chk("zero_flag", 32'(zero_flag), 32'(m_zf));
`endif
    end
  end

  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit rr, input bit rst);
    @(posedge clk);
    #1;
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.result_ready = rr;
    reset            = rst;
  endtask

  // Leaves the block in HOLD with the result presented.
  task automatic load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic consume();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b1; bus.in_data = 4'h9; bus.result_ready = 1'b0;

    // Reset held for three cycles with in_valid high.
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_rv", 32'(bus.result_valid), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_inputA", 32'(inputA), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic AND.
    load(4'b1100, 4'b1010);
    @(negedge clk);
    chk("basic_inputA", 32'(inputA), 32'hC);
    chk("basic_inputB", 32'(inputB), 32'hA);
    chk("basic_result", 32'(bus.result), 32'h8);
    consume();
    @(negedge clk);
    chk("basic_count", 32'(op_count), 32'd1);

    // Backpressure with extra beats offered during EXEC/HOLD.
    step(1'b1, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_rv", 32'(bus.result_valid), 32'd1);
    chk("bp_result", 32'(bus.result), 32'h5);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    consume();
    @(negedge clk);
    chk("bp_count", 32'(op_count), 32'd2);
    chk("bp_rv_clear", 32'(bus.result_valid), 32'd0);

    // Count wrap: 254 more operations reach 256 -> 0, one more -> 1.
    for (int i = 0; i < 254; i++) begin
      load(4'($urandom), 4'($urandom));
      consume();
    end
    @(negedge clk);
    chk("wrap_zero", 32'(op_count), 32'd0);
    load(4'h7, 4'h3);
    consume();
    @(negedge clk);
    chk("wrap_one", 32'(op_count), 32'd1);

`ifdef ALU_ZERO_FLAG_EN
    load(4'b0101, 4'b1010);
    @(negedge clk);
    chk("zf_result", 32'(bus.result), 32'd0);
    chk("zf_set", 32'(zero_flag), 32'd1);
    consume();
    load(4'hF, 4'h1);
    @(negedge clk);
    chk("zf_clear", 32'(zero_flag), 32'd0);
    consume();
`endif

    // Reset while holding a result.
    load(4'h3, 4'hC);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_rst_rv", 32'(bus.result_valid), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);

    // Random traffic, occasional reset.
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 59) == 0));
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
